// File: rtl/serial_frame_capture.sv
// rtl/serial_frame_capture.sv - sync-word hunter and MSB-first frame capture with valid/ready output
module serial_frame_capture #(
    parameter int                DATA_W   = 8,
    parameter int                SYNC_W   = 4,
    parameter logic [SYNC_W-1:0] SYNC_PAT = 4'b1011,
    parameter int                CNT_W    = 8
) (
    input  logic              clk,
    input  logic              res,
    input  logic              din,
    input  logic              din_en,
    output logic [DATA_W-1:0] frame_data,
    output logic              frame_valid,
    input  logic              frame_ready,
    output logic              sync_lock,
    output logic [CNT_W-1:0]  frame_cnt,
    output logic              ovf
);

    localparam int FILL_W = (SYNC_W > 2) ? $clog2(SYNC_W) : 1;
    localparam int BIT_W  = (DATA_W > 2) ? $clog2(DATA_W) : 1;
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(SYNC_W - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(DATA_W - 1);

    typedef enum logic {HUNT, CAPTURE} state_t;

    state_t              state, state_n;
    logic [SYNC_W-2:0]   sh, sh_n;
    logic [FILL_W-1:0]   fill, fill_n;
    logic [BIT_W-1:0]    bit_cnt, bit_cnt_n;
    logic [DATA_W-2:0]   cap, cap_n;
    logic [SYNC_W-1:0]   sync_word;
    logic [DATA_W-1:0]   frame_word;
    logic                complete;
    logic                accept;

    // The shifter and capture register keep one bit fewer than a full word;
    // the incoming bit completes the word that is compared or delivered.
    assign sync_word  = {sh, din};
    assign frame_word = {cap, din};
    assign accept     = frame_valid & frame_ready;
    assign sync_lock  = (state == CAPTURE);

    always_comb begin
        state_n   = state;
        sh_n      = sh;
        fill_n    = fill;
        bit_cnt_n = bit_cnt;
        cap_n     = cap;
        complete  = 1'b0;
        if (din_en) begin
            case (state)
                HUNT: begin
                    sh_n = sync_word[SYNC_W-2:0];
                    if (fill != FILL_MAX)
                        fill_n = fill + 1'b1;
                    // fill saturates one short of SYNC_W: at the cap, this bit makes a full window
                    if (fill == FILL_MAX && sync_word == SYNC_PAT) begin
                        state_n   = CAPTURE;
                        bit_cnt_n = '0;
                    end
                end
                CAPTURE: begin
                    cap_n     = frame_word[DATA_W-2:0];
                    bit_cnt_n = bit_cnt + 1'b1;
                    if (bit_cnt == BIT_LAST) begin
                        complete  = 1'b1;
                        state_n   = HUNT;
                        sh_n      = '0;
                        fill_n    = '0;
                        bit_cnt_n = '0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state       <= HUNT;
            sh          <= '0;
            fill        <= '0;
            bit_cnt     <= '0;
            cap         <= '0;
            frame_data  <= '0;
            frame_valid <= 1'b0;
            frame_cnt   <= '0;
            ovf         <= 1'b0;
        end else begin
            state   <= state_n;
            sh      <= sh_n;
            fill    <= fill_n;
            bit_cnt <= bit_cnt_n;
            cap     <= cap_n;
            if (accept)
                frame_cnt <= frame_cnt + 1'b1;
            if (complete) begin
                if (!frame_valid || accept) begin
                    frame_data  <= frame_word;
                    frame_valid <= 1'b1;
                end else begin
                    ovf <= 1'b1;
                end
            end else if (accept) begin
                frame_valid <= 1'b0;
            end
        end
    end

endmodule
